// File: rtl/io_seg_display_port.sv
// Memory-mapped six-digit 7-segment output port. Stored 8-bit values are converted to two
// decimal digits per pair by one shared sequential double-dabble engine.
module io_seg_display_port #(
    parameter bit BLANK_TENS_ZERO = 1'b0,
    parameter int SHIFT_BITS      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        busy,
    output logic [41:0] io_out
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [2:0] LAST_SHIFT = 3'(SHIFT_BITS - 1);
    localparam logic [6:0] SEG_ZERO  = 7'b100_0000;
    localparam logic [6:0] SEG_ERR   = 7'b000_0110;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    logic [1:0]  state_r;
    logic [7:0]  value_r [0:2];
    logic [2:0]  pending_r;
    logic [1:0]  sel_r;
    logic        over_r;
    logic [19:0] shift_r;
    logic [2:0]  count_r;
    logic        busy_r;
    logic [41:0] seg_r;

    logic [2:0]  write_hit_s;
    logic [1:0]  lowest_s;
    logic [7:0]  load_val_s;
    logic [2:0]  clear_s;
    logic [2:0]  pending_next_s;
    logic [6:0]  tens_seg_s;
    logic [6:0]  ones_seg_s;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b100_0000;
            4'd1:    s = 7'b111_1001;
            4'd2:    s = 7'b010_0100;
            4'd3:    s = 7'b011_0000;
            4'd4:    s = 7'b001_1001;
            4'd5:    s = 7'b001_0010;
            4'd6:    s = 7'b000_0010;
            4'd7:    s = 7'b111_1000;
            4'd8:    s = 7'b000_0000;
            4'd9:    s = 7'b001_0000;
            default: s = SEG_ERR;
        endcase
        return s;
    endfunction

    // One double-dabble iteration over {hundreds, tens, ones, binary}: correct then shift.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int k = 0; k < 3; k++) begin
            t[8 + 4*k +: 4] = (t[8 + 4*k +: 4] >= 4'd5) ? (t[8 + 4*k +: 4] + 4'd3)
                                                          : t[8 + 4*k +: 4];
        end
        return {t[18:0], 1'b0};
    endfunction

    // Write decode, lowest-pending pick and pending-bit bookkeeping.
    always_comb begin
        write_hit_s = 3'b000;
        if (wr_en && (wr_addr != 2'd3)) begin
            write_hit_s[wr_addr] = 1'b1;
        end else begin
            write_hit_s = 3'b000;
        end

        if (pending_r[0]) begin
            lowest_s = 2'd0;
        end else if (pending_r[1]) begin
            lowest_s = 2'd1;
        end else begin
            lowest_s = 2'd2;
        end

        case (lowest_s)
            2'd0:    load_val_s = value_r[0];
            2'd1:    load_val_s = value_r[1];
            default: load_val_s = value_r[2];
        endcase

        clear_s = 3'b000;
        if ((state_r == ST_IDLE) && (pending_r != 3'b000)) begin
            clear_s[lowest_s] = 1'b1;
        end else begin
            clear_s = 3'b000;
        end
        // A write on the load edge wins, so the pair is converted again with the new value.
        pending_next_s = (pending_r & ~clear_s) | write_hit_s;
    end

    // Glyphs for the pair being committed.
    always_comb begin
        if (over_r) begin
            tens_seg_s = SEG_ERR;
            ones_seg_s = SEG_ERR;
        end else begin
            ones_seg_s = seg_of(shift_r[11:8]);
            if (BLANK_TENS_ZERO && (shift_r[15:12] == 4'd0)) begin
                tens_seg_s = SEG_BLANK;
            end else begin
                tens_seg_s = seg_of(shift_r[15:12]);
            end
        end
    end

    // Value registers, pending flags, conversion FSM and committed segment state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            value_r[0] <= 8'd0;
            value_r[1] <= 8'd0;
            value_r[2] <= 8'd0;
            pending_r  <= 3'b000;
            sel_r      <= 2'd0;
            over_r     <= 1'b0;
            shift_r    <= 20'd0;
            count_r    <= 3'd0;
            busy_r     <= 1'b0;
            seg_r      <= {6{SEG_ZERO}};
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (write_hit_s[i]) begin
                    value_r[i] <= wr_data;
                end
            end
            pending_r <= pending_next_s;
            busy_r    <= (pending_r != 3'b000) || (state_r != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (pending_r != 3'b000) begin
                        sel_r   <= lowest_s;
                        shift_r <= {12'd0, load_val_s};
                        over_r  <= (load_val_s >= 8'd100);
                        count_r <= 3'd0;
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_r <= dabble_step(shift_r);
                    count_r <= count_r + 3'd1;
                    if (count_r == LAST_SHIFT) begin
                        state_r <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    case (sel_r)
                        2'd0:    seg_r[13:0]  <= {tens_seg_s, ones_seg_s};
                        2'd1:    seg_r[27:14] <= {tens_seg_s, ones_seg_s};
                        2'd2:    seg_r[41:28] <= {tens_seg_s, ones_seg_s};
                        default: seg_r        <= seg_r;
                    endcase
                    state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign busy   = busy_r;
    assign io_out = seg_r;

endmodule

// File: tb/tb_io_seg_display_port.sv
// Bench for io_seg_display_port: cycle-level behavioural model checked every cycle, plus
// directed vectors with hand-computed glyph expectations.
module tb_io_seg_display_port;

    localparam logic [6:0] S0 = 7'b100_0000;
    localparam logic [6:0] S1 = 7'b111_1001;
    localparam logic [6:0] S2 = 7'b010_0100;
    localparam logic [6:0] S3 = 7'b011_0000;
    localparam logic [6:0] S4 = 7'b001_1001;
    localparam logic [6:0] S5 = 7'b001_0010;
    localparam logic [6:0] S7 = 7'b111_1000;
    localparam logic [6:0] S9 = 7'b001_0000;
    localparam logic [6:0] SE = 7'b000_0110;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic [41:0] io_out;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    io_seg_display_port dut (
        .clock   (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .io_out  (io_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex(input int n);
        return io_out[7*n +: 7];
    endfunction

    // Behavioural model: a job takes 10 edges from the load edge to the commit edge inclusive.
    logic [6:0]  glyph [0:9];
    int          m_val  [0:2];
    bit          m_pend [0:2];
    bit          m_active;
    int          m_remain;
    int          m_sel;
    int          m_snap;
    logic [41:0] m_seg;
    bit          m_busy;
    bit          m_any;

    initial begin
        glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
        glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
        glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
        glyph[9] = 7'b0010000;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_val[i]  = 0;
                m_pend[i] = 1'b0;
            end
            m_active = 1'b0;
            m_remain = 0;
            m_sel    = 0;
            m_snap   = 0;
            m_busy   = 1'b0;
            m_seg    = {6{glyph[0]}};
        end else begin
            m_any  = m_pend[0] || m_pend[1] || m_pend[2];
            m_busy = m_any || m_active;
            if (m_active) begin
                if (m_remain == 0) begin
                    if (m_snap >= 100) begin
                        m_seg[14*m_sel +: 14] = {SE, SE};
                    end else begin
                        m_seg[14*m_sel +: 14] = {glyph[m_snap / 10], glyph[m_snap % 10]};
                    end
                    m_active = 1'b0;
                end else begin
                    m_remain = m_remain - 1;
                end
            end else if (m_any) begin
                m_sel = m_pend[0] ? 0 : (m_pend[1] ? 1 : 2);
                m_snap = m_val[m_sel];
                m_pend[m_sel] = 1'b0;
                m_active = 1'b1;
                m_remain = 8;
            end
            if (wr_en && (wr_addr != 2'd3)) begin
                m_val[wr_addr]  = int'(wr_data);
                m_pend[wr_addr] = 1'b1;
            end
        end
    end

    // Compare DUT against the model shortly after every active edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("model_io_out", 64'(io_out), 64'(m_seg));
            check("model_busy", 64'(busy), 64'(m_busy));
        end
    end

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        // T1: reset state
        check("t1_io_out", 64'(io_out), 64'({6{S0}}));
        check("t1_busy", 64'(busy), 64'(1'b0));

        // T2: 42 on pair 0, visible exactly 10 edges after the write
        wr(2'd0, 8'd42);
        repeat (9) @(negedge clk);
        check("t2_hex1_n9", 64'(hex(1)), 64'(S0));
        check("t2_hex0_n9", 64'(hex(0)), 64'(S0));
        @(negedge clk);
        check("t2_hex1_n10", 64'(hex(1)), 64'(S4));
        check("t2_hex0_n10", 64'(hex(0)), 64'(S2));
        check("t2_busy_n10", 64'(busy), 64'(1'b1));
        @(negedge clk);
        check("t2_busy_n11", 64'(busy), 64'(1'b0));

        // T3: engine busy with pair 0 while pair 2 then pair 1 are written; pair 1 goes first
        wr(2'd0, 8'd5);
        repeat (8) @(negedge clk);
        wr(2'd2, 8'd7);
        wr(2'd1, 8'd99);
        check("t3_hex0_pre", 64'(hex(0)), 64'(S5));
        check("t3_hex1_pre", 64'(hex(1)), 64'(S0));
        repeat (9) @(negedge clk);
        check("t3_hex2_n10", 64'(hex(2)), 64'(S0));
        @(negedge clk);
        check("t3_hex3_n11", 64'(hex(3)), 64'(S9));
        check("t3_hex2_n11", 64'(hex(2)), 64'(S9));
        check("t3_hex4_n11", 64'(hex(4)), 64'(S0));
        repeat (9) @(negedge clk);
        check("t3_hex4_n20", 64'(hex(4)), 64'(S0));
        @(negedge clk);
        check("t3_hex5_n21", 64'(hex(5)), 64'(S0));
        check("t3_hex4_n21", 64'(hex(4)), 64'(S7));

        // T4: out-of-range value shows E E; address 3 is ignored
        repeat (2) @(negedge clk);
        wr(2'd0, 8'd200);
        repeat (10) @(negedge clk);
        check("t4_hex1_err", 64'(hex(1)), 64'(SE));
        check("t4_hex0_err", 64'(hex(0)), 64'(SE));
        repeat (2) @(negedge clk);
        wr(2'd3, 8'd55);
        @(negedge clk);
        check("t4_addr3_busy", 64'(busy), 64'(1'b0));
        repeat (11) @(negedge clk);
        check("t4_addr3_io", 64'(io_out), 64'({S0, S7, S9, S9, SE, SE}));
        check("t4_addr3_busy_late", 64'(busy), 64'(1'b0));

        // T5: rewrite during conversion commits the snapshot first, then the new value
        wr(2'd0, 8'd12);
        repeat (3) @(negedge clk);
        wr(2'd0, 8'd34);
        repeat (5) @(negedge clk);
        check("t5_hex0_n9", 64'(hex(0)), 64'(SE));
        @(negedge clk);
        check("t5_hex1_n10", 64'(hex(1)), 64'(S1));
        check("t5_hex0_n10", 64'(hex(0)), 64'(S2));
        repeat (9) @(negedge clk);
        check("t5_hex0_n19", 64'(hex(0)), 64'(S2));
        @(negedge clk);
        check("t5_hex1_n20", 64'(hex(1)), 64'(S3));
        check("t5_hex0_n20", 64'(hex(0)), 64'(S4));

        // T6: reset mid-conversion aborts it
        repeat (2) @(negedge clk);
        wr(2'd1, 8'd88);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_io_out", 64'(io_out), 64'({6{S0}}));
        check("t6_busy", 64'(busy), 64'(1'b0));
        repeat (15) @(negedge clk);
        check("t6_io_out_late", 64'(io_out), 64'({6{S0}}));
        check("t6_busy_late", 64'(busy), 64'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
